alu_exec_unit: RTL and testbench

//   Execute stage downstream of the instruction register/controller. Holds

---
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/alu_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Op handshake and result bus between the controller (master) and the execute unit (slave).
// An op transfers on a rising edge where op_valid && op_ready; op_valid while op_ready is low is dropped, not held.
interface alu_exec_unit_if #(
  parameter int WIDTH = 8
);
  logic             op_valid;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] ld_data;
  logic             op_ready;
  logic             done;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output op_valid, op_code, ld_data,
    input  op_ready, done, a_out, b_out, flag_z, flag_c, flag_v
  );

  modport slave (
    input  op_valid, op_code, ld_data,
    output op_ready, done, a_out, b_out, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: A/B working registers, single-cycle LDA/LDB/ADD/SUB and
// WIDTH-step shift-add MUL / restoring DIV, with a one-cycle done pulse per op.
module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  alu_exec_unit_if.slave      bus,
  output logic [1:0]          state_dbg
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_LDA = 4'b1000;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1010;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             z_q, c_q, v_q, done_q;
  // Iteration workspace: hi = partial product / remainder, lo = multiplier / quotient.
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign accept    = bus.op_valid && (state_q == S_IDLE);
  assign last_step = (cnt_q == CW'(1));
  assign add_sum   = {1'b0, a_q} + {1'b0, b_q};

  // One shift-add step: add multiplicand into the high half when the current multiplier bit is set, then shift right.
  assign mul_sum  = {1'b0, hi_q} + {1'b0, opnd_q};
  assign mul_next = lo_q[0] ? {mul_sum, lo_q[WIDTH-1:1]}
                            : {1'b0, hi_q, lo_q[WIDTH-1:1]};

  // Remainder stays below the divisor, so the trial difference needs only one extra bit for its sign.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign rem_next  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_next  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && bus.op_code == OP_MUL)                    state_d = S_MUL;
        else if (accept && bus.op_code == OP_DIV && b_q != '0)  state_d = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (last_step) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            done_q <= 1'b1;
            case (bus.op_code)
              OP_LDA: a_q <= bus.ld_data;
              OP_LDB: b_q <= bus.ld_data;
              OP_ADD: begin
                a_q <= add_sum[WIDTH-1:0];
                c_q <= add_sum[WIDTH];
                z_q <= (add_sum[WIDTH-1:0] == '0);
              end
              OP_SUB: begin
                a_q <= a_q - b_q;
                c_q <= (a_q < b_q);
                z_q <= (a_q == b_q);
              end
              OP_MUL: begin
                done_q <= 1'b0;
                hi_q   <= '0;
                lo_q   <= a_q;
                opnd_q <= b_q;
                cnt_q  <= CW'(WIDTH);
              end
              OP_DIV: begin
                if (b_q == '0) begin
                  a_q <= '1;
                  v_q <= 1'b1;
                  c_q <= 1'b0;
                  z_q <= 1'b0;
                end else begin
                  done_q <= 1'b0;
                  hi_q   <= '0;
                  lo_q   <= a_q;
                  opnd_q <= b_q;
                  cnt_q  <= CW'(WIDTH);
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          {hi_q, lo_q} <= mul_next;
          cnt_q        <= cnt_q - CW'(1);
          if (last_step) begin
            a_q    <= mul_next[WIDTH-1:0];
            v_q    <= (mul_next[2*WIDTH-1:WIDTH] != '0);
            z_q    <= (mul_next[WIDTH-1:0] == '0);
            c_q    <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DIV: begin
          hi_q  <= rem_next;
          lo_q  <= quo_next;
          cnt_q <= cnt_q - CW'(1);
          if (last_step) begin
            a_q    <= quo_next;
            b_q    <= rem_next;
            z_q    <= (quo_next == '0);
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op_ready = (state_q == S_IDLE);
  assign bus.done     = done_q;
  assign bus.a_out    = a_q;
  assign bus.b_out    = b_q;
  assign bus.flag_z   = z_q;
  assign bus.flag_c   = c_q;
  assign bus.flag_v   = v_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: each task drives one scenario and checks
// its results inline against hand-computed values.
module tb_alu_exec_unit;
  localparam logic [3:0] OP_LDA = 4'b1000;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1100;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_JMP = 4'b1001;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;
  int         total = 0;
  int         bad = 0;

  alu_exec_unit_if #(.WIDTH(8)) bus();

  alu_exec_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Drives one op for one cycle; returns #1 after the accepting edge (cycle N+1).
  task automatic do_op(input logic [3:0] op, input logic [7:0] data);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.ld_data  = data;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.ld_data  = 8'h00;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = 4'b0000;
    bus.ld_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready}
        !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got a=%h b=%h zcv=%b%b%b done=%b rdy=%b want a=00 b=00 zcv=000 done=0 rdy=1",
               bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready);
    end
  endtask

  task automatic test_load_add();
    do_op(OP_LDA, 8'h07);
    total++;
    if ({bus.a_out, bus.done} !== {8'h07, 1'b1}) begin
      bad++; $display("FAIL lda: got a=%h done=%b want a=07 done=1", bus.a_out, bus.done);
    end
    do_op(OP_LDB, 8'h05);
    total++;
    if ({bus.b_out, bus.a_out, bus.done} !== {8'h05, 8'h07, 1'b1}) begin
      bad++; $display("FAIL ldb: got b=%h a=%h done=%b want b=05 a=07 done=1", bus.b_out, bus.a_out, bus.done);
    end
    do_op(OP_ADD, 8'hAA);
    total++;
    if ({bus.a_out, bus.flag_z, bus.flag_c, bus.done} !== {8'h0C, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL add_basic: got a=%h z=%b c=%b done=%b want a=0c z=0 c=0 done=1",
                      bus.a_out, bus.flag_z, bus.flag_c, bus.done);
    end
    idle_cycle();
    total++;
    if ({bus.done, bus.a_out} !== {1'b0, 8'h0C}) begin
      bad++; $display("FAIL done_single: got done=%b a=%h want done=0 a=0c", bus.done, bus.a_out);
    end
    do_op(OP_JMP, 8'h33);
    total++;
    if ({bus.a_out, bus.b_out, bus.done} !== {8'h0C, 8'h05, 1'b1}) begin
      bad++; $display("FAIL other_op: got a=%h b=%h done=%b want a=0c b=05 done=1", bus.a_out, bus.b_out, bus.done);
    end
  endtask

  task automatic test_carry_sub();
    do_op(OP_LDA, 8'hFF);
    do_op(OP_LDB, 8'h01);
    do_op(OP_ADD, 8'h00);
    total++;
    if ({bus.a_out, bus.flag_z, bus.flag_c, bus.done} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL add_carry: got a=%h z=%b c=%b done=%b want a=00 z=1 c=1 done=1",
                      bus.a_out, bus.flag_z, bus.flag_c, bus.done);
    end
    do_op(OP_LDA, 8'h03);
    do_op(OP_LDB, 8'h05);
    do_op(OP_SUB, 8'h00);
    total++;
    if ({bus.a_out, bus.flag_z, bus.flag_c, bus.flag_v} !== {8'hFE, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sub_borrow: got a=%h z=%b c=%b v=%b want a=fe z=0 c=1 v=0",
                      bus.a_out, bus.flag_z, bus.flag_c, bus.flag_v);
    end
    do_op(OP_LDA, 8'h05);
    do_op(OP_SUB, 8'h00);
    total++;
    if ({bus.a_out, bus.flag_z, bus.flag_c} !== {8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sub_zero: got a=%h z=%b c=%b want a=00 z=1 c=0", bus.a_out, bus.flag_z, bus.flag_c);
    end
  endtask

  // Runs a multi-cycle op whose operands are already loaded; returns at cycle N+9.
  task automatic run_multi(input logic [3:0] op, input logic [7:0] a_pre, input string tag);
    int busy_bad;
    busy_bad = 0;
    do_op(op, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      if (bus.op_ready !== 1'b0 || bus.done !== 1'b0 || bus.a_out !== a_pre) busy_bad++;
      idle_cycle();
    end
    total++;
    if (busy_bad != 0) begin
      bad++; $display("FAIL %s_busy: %0d busy cycles wrong (want rdy=0 done=0 a=%h)", tag, busy_bad, a_pre);
    end
  endtask

  task automatic test_mul();
    do_op(OP_LDA, 8'h10);
    do_op(OP_LDB, 8'h11);
    run_multi(OP_MUL, 8'h10, "mul_ovf");
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready}
        !== {8'h10, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL mul_ovf: got a=%h b=%h zcv=%b%b%b done=%b rdy=%b want a=10 b=11 zcv=001 done=1 rdy=1",
                      bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready);
    end
    do_op(OP_LDA, 8'h0F);
    do_op(OP_LDB, 8'h03);
    run_multi(OP_MUL, 8'h0F, "mul_small");
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_z, bus.flag_v, bus.done} !== {8'h2D, 8'h03, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL mul_small: got a=%h b=%h z=%b v=%b done=%b want a=2d b=03 z=0 v=0 done=1",
                      bus.a_out, bus.b_out, bus.flag_z, bus.flag_v, bus.done);
    end
  endtask

  task automatic test_div();
    do_op(OP_LDA, 8'h64);
    do_op(OP_LDB, 8'h07);
    run_multi(OP_DIV, 8'h64, "div");
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done}
        !== {8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL div: got a=%h b=%h zcv=%b%b%b done=%b want a=0e b=02 zcv=000 done=1",
                      bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done);
    end
    do_op(OP_LDA, 8'h03);
    do_op(OP_LDB, 8'h09);
    run_multi(OP_DIV, 8'h03, "div_small");
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_z} !== {8'h00, 8'h03, 1'b1}) begin
      bad++; $display("FAIL div_small: got a=%h b=%h z=%b want a=00 b=03 z=1", bus.a_out, bus.b_out, bus.flag_z);
    end
    do_op(OP_LDA, 8'h05);
    do_op(OP_LDB, 8'h00);
    do_op(OP_DIV, 8'h00);
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready}
        !== {8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
      bad++; $display("FAIL div_zero: got a=%h b=%h zcv=%b%b%b done=%b rdy=%b want a=ff b=00 zcv=001 done=1 rdy=1",
                      bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int early_done;
    early_done = 0;
    do_op(OP_LDA, 8'h03);
    do_op(OP_LDB, 8'h04);
    do_op(OP_MUL, 8'h00);
    bus.op_valid = 1'b1;
    bus.op_code  = OP_ADD;
    for (int k = 1; k <= 8; k++) begin
      if (bus.done !== 1'b0 || bus.a_out !== 8'h03) early_done++;
      idle_cycle();
    end
    bus.op_valid = 1'b0;
    total++;
    if (early_done != 0 || {bus.a_out, bus.done} !== {8'h0C, 1'b1}) begin
      bad++; $display("FAIL busy_ignore: got a=%h done=%b busy_errs=%0d want a=0c done=1 busy_errs=0",
                      bus.a_out, bus.done, early_done);
    end
    idle_cycle();
    total++;
    if ({bus.a_out, bus.done} !== {8'h0C, 1'b0}) begin
      bad++; $display("FAIL busy_no_queue: got a=%h done=%b want a=0c done=0", bus.a_out, bus.done);
    end
  endtask

  task automatic test_reset_abort();
    int late_done;
    late_done = 0;
    do_op(OP_LDA, 8'h10);
    do_op(OP_LDB, 8'h11);
    do_op(OP_SUB, 8'h00);   // leaves c=1 so the flag clear is observable
    do_op(OP_MUL, 8'h00);
    repeat (3) idle_cycle();
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready}
        !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_abort: got a=%h b=%h zcv=%b%b%b done=%b rdy=%b want a=00 b=00 zcv=000 done=0 rdy=1",
                      bus.a_out, bus.b_out, bus.flag_z, bus.flag_c, bus.flag_v, bus.done, bus.op_ready);
    end
    for (int k = 0; k < 12; k++) begin
      if (bus.done !== 1'b0 || bus.op_ready !== 1'b1) late_done++;
      idle_cycle();
    end
    total++;
    if (late_done != 0) begin
      bad++; $display("FAIL reset_no_late_done: got %0d bad cycles want 0", late_done);
    end
  endtask

  task automatic test_back_to_back();
    do_op(OP_LDA, 8'h20);
    do_op(OP_LDB, 8'h08);
    do_op(OP_ADD, 8'h00);
    do_op(OP_SUB, 8'h00);
    total++;
    if ({bus.a_out, bus.b_out, bus.flag_c, bus.done} !== {8'h20, 8'h08, 1'b0, 1'b1}) begin
      bad++; $display("FAIL back_to_back: got a=%h b=%h c=%b done=%b want a=20 b=08 c=0 done=1",
                      bus.a_out, bus.b_out, bus.flag_c, bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_carry_sub();
    test_mul();
    test_div();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
